// File: rtl/ef_smsdac8_pkg.sv
// Shared types and constants for the SMS DAC8 front end (interpolator and status counters).
package ef_smsdac8_pkg;

  localparam logic [7:0] MIDSCALE = 8'h80;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // The accumulator carries L_LOG2 fractional bits below the 8-bit sample.
  function automatic int acc_width(input int l_log2);
    return 8 + l_log2;
  endfunction

endpackage

// File: rtl/ef_sat_cnt.sv
// Saturating up-counter with synchronous clear; the clear has priority over the increment.
module ef_sat_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_b,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ef_smsdac8_interp.sv
// Linear-interpolating upsampler feeding the 8-b SMS DAC core: ramps o_x to each new
// sample over 2^L_LOG2 clocks and flags slots that close without a fresh sample.
module ef_smsdac8_interp
  import ef_smsdac8_pkg::*;
#(
  parameter int L_LOG2  = 2,
  parameter int W_URCNT = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_b,
  input  logic               i_valid,
  input  logic [7:0]         i_x,
  output logic               o_ready,
  output logic [7:0]         o_x,
  output logic               o_urun,
  output logic [W_URCNT-1:0] o_urun_cnt,
  input  logic               i_clr_urun
);

  localparam int ACC_W = acc_width(L_LOG2);
  localparam logic [ACC_W-1:0] ACC_MID = ACC_W'(MIDSCALE) << L_LOG2;
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(8'hFF) << L_LOG2;

  state_e              r_state;
  logic [ACC_W-1:0]    r_acc;
  logic signed [8:0]   r_delta;
  logic [7:0]          r_tgt;
  logic [L_LOG2-1:0]   r_cnt;
  logic                r_urun;

  logic                w_slot_end;
  logic                w_urun_evt;
  logic signed [ACC_W-1:0] w_dext;
  logic signed [8:0]   w_delta_idle;
  logic signed [8:0]   w_delta_run;

  assign w_slot_end   = (r_state == RUN) && (r_cnt == '1);
  assign w_urun_evt   = w_slot_end && !i_valid;
  assign o_ready      = (r_state == IDLE) || w_slot_end;

  assign w_dext       = ACC_W'(r_delta);
  assign w_delta_idle = $signed({1'b0, i_x}) - $signed({1'b0, MIDSCALE});
  assign w_delta_run  = $signed({1'b0, i_x}) - $signed({1'b0, r_tgt});

  // delta*2^L_LOG2 equals the full sample step, so the ramp lands exactly on tgt.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_state <= IDLE;
      r_acc   <= ACC_MID;
      r_delta <= '0;
      r_tgt   <= MIDSCALE;
      r_cnt   <= '0;
      r_urun  <= 1'b0;
    end else begin
      r_urun <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_delta <= w_delta_idle;
            r_tgt   <= i_x;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= r_acc + $unsigned(w_dext);
          r_cnt <= r_cnt + L_LOG2'(1);
          if (w_slot_end) begin
            if (i_valid) begin
              r_delta <= w_delta_run;
              r_tgt   <= i_x;
            end else begin
              r_delta <= '0;
              r_urun  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_x    = r_acc[L_LOG2+7:L_LOG2];
  assign o_urun = r_urun;

  ef_sat_cnt #(
    .W (W_URCNT)
  ) u_urun_cnt (
    .i_clk   (i_clk),
    .i_rst_b (i_rst_b),
    .i_inc   (w_urun_evt),
    .i_clr   (i_clr_urun),
    .o_cnt   (o_urun_cnt)
  );

  a_acc_range: assert property (@(posedge i_clk) disable iff (!i_rst_b) r_acc <= ACC_MAX);

endmodule
